// File: rtl/video_in_decoder.sv
// Receive-side video timing decoder: recovers pixel coordinates and frame/line markers,
// measures timing against the mode, locks, and counts errors. Optional CRC: VIDEO_IN_CRC_EN.
module video_in_decoder #(
  parameter int H_ACTIVE_VIDEO = 1024,
  parameter int H_FRONT_PORCH  = 24,
  parameter int H_SYNC_WIDTH   = 136,
  parameter int H_BACK_PORCH   = 160,
  parameter int V_ACTIVE_VIDEO = 768,
  parameter int V_FRONT_PORCH  = 3,
  parameter int V_SYNC_WIDTH   = 6,
  parameter int V_BACK_PORCH   = 29,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [23:0] video_in_pData,
  input  logic        video_in_pHSync,
  input  logic        video_in_pVSync,
  input  logic        video_in_pVDE,
  output logic [23:0] pixel_color,
  output logic        pixel_valid,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic        sof,
  output logic        eol,
  output logic        locked,
  output logic [15:0] err_count,
  output logic [1:0]  dbg_state
`ifdef VIDEO_IN_CRC_EN
  ,
  output logic [31:0] frame_crc,
  output logic        frame_crc_valid
`endif
);

  localparam logic [15:0] LP_H_ACT   = 16'(H_ACTIVE_VIDEO);
  localparam logic [15:0] LP_H_FRAME = 16'(H_ACTIVE_VIDEO + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH);
  localparam logic [15:0] LP_HS_W    = 16'(H_SYNC_WIDTH);
  localparam logic [15:0] LP_V_ACT   = 16'(V_ACTIVE_VIDEO);
  localparam logic [15:0] LP_V_FRAME = 16'(V_ACTIVE_VIDEO + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH);
  localparam logic [15:0] LP_LOCK    = 16'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 1 captures the wire; the _d copy is the sample being decoded, the
  // undelayed copy is its successor, so every edge is seen between the two.
  logic [23:0] r_data, r_data_d;
  logic        r_hs, r_hs_d, r_vs, r_vs_d, r_de, r_de_d;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_data_d <= '0;
      r_hs     <= 1'b0;
      r_hs_d   <= 1'b0;
      r_vs     <= 1'b0;
      r_vs_d   <= 1'b0;
      r_de     <= 1'b0;
      r_de_d   <= 1'b0;
    end else begin
      r_data   <= video_in_pData;
      r_hs     <= video_in_pHSync;
      r_vs     <= video_in_pVSync;
      r_de     <= video_in_pVDE;
      r_data_d <= r_data;
      r_hs_d   <= r_hs;
      r_vs_d   <= r_vs;
      r_de_d   <= r_de;
    end
  end

  state_t      r_state, w_state_nxt;
  logic [15:0] r_match_cnt, w_match_cnt_nxt;
  logic [15:0] r_x, r_y, r_h_act, r_hcyc, r_h_tot, r_hs_cnt, r_hs_w, r_vfall, r_hrise;
  logic        r_perr_seen;

  logic        w_de_fall, w_hs_rise, w_hs_fall, w_vs_rise, w_active, w_perr, w_match, w_frame_err;
  logic        w_pix;
  logic [23:0] w_color;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;
  logic [15:0] w_h_act_eff, w_h_tot_eff, w_hs_w_eff, w_v_act_eff, w_v_tot_eff;

  assign w_de_fall = r_de_d & ~r_de;
  assign w_hs_rise = ~r_hs_d & r_hs;
  assign w_hs_fall = r_hs_d & ~r_hs;
  assign w_vs_rise = ~r_vs_d & r_vs;
  assign w_active  = (r_state != ST_SEARCH);
  assign w_pix     = w_active & r_de_d;
  assign w_color   = {r_data_d[23:16], r_data_d[7:0], r_data_d[15:8]};
  assign w_perr    = w_active & r_de_d & (r_hs_d | r_vs_d) & ~r_perr_seen;
  assign dbg_state = r_state;

  // Events in the same sample as the VSync rise are folded in before the compare.
  assign w_h_act_eff = w_de_fall ? sat_inc(r_x) : r_h_act;
  assign w_h_tot_eff = w_hs_rise ? sat_inc(r_hcyc) : r_h_tot;
  assign w_hs_w_eff  = w_hs_fall ? r_hs_cnt : r_hs_w;
  assign w_v_act_eff = w_de_fall ? sat_inc(r_vfall) : r_vfall;
  assign w_v_tot_eff = w_hs_rise ? sat_inc(r_hrise) : r_hrise;
  assign w_match = (w_h_act_eff == LP_H_ACT) && (w_h_tot_eff == LP_H_FRAME) &&
                   (w_hs_w_eff == LP_HS_W) && (w_v_act_eff == LP_V_ACT) &&
                   (w_v_tot_eff == LP_V_FRAME);

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_h_act     <= '0;
      r_hcyc      <= '0;
      r_h_tot     <= '0;
      r_hs_cnt    <= '0;
      r_hs_w      <= '0;
      r_vfall     <= '0;
      r_hrise     <= '0;
      r_perr_seen <= 1'b0;
    end else begin
      r_x    <= r_de_d ? sat_inc(r_x) : 16'd0;
      r_hcyc <= w_hs_rise ? 16'd0 : sat_inc(r_hcyc);
      if (w_de_fall) r_h_act <= sat_inc(r_x);
      if (w_hs_rise) r_h_tot <= sat_inc(r_hcyc);
      if (r_hs) r_hs_cnt <= r_hs_d ? sat_inc(r_hs_cnt) : 16'd1;
      if (w_hs_fall) r_hs_w <= r_hs_cnt;
      if (w_vs_rise) begin
        r_y     <= '0;
        r_vfall <= '0;
        r_hrise <= '0;
      end else begin
        if (w_de_fall) r_y     <= sat_inc(r_y);
        if (w_de_fall) r_vfall <= sat_inc(r_vfall);
        if (w_hs_rise) r_hrise <= sat_inc(r_hrise);
      end
      // One protocol error per line: the flag re-arms on each HSync rise.
      if (w_hs_rise) r_perr_seen <= 1'b0;
      if (w_perr)    r_perr_seen <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_match_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_frame_err     = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_rise) begin
          w_state_nxt     = ST_MEASURE;
          w_match_cnt_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (w_vs_rise) begin
          if (w_match) begin
            w_match_cnt_nxt = sat_inc(r_match_cnt);
            if (sat_inc(r_match_cnt) >= LP_LOCK) w_state_nxt = ST_LOCKED;
          end else begin
            w_match_cnt_nxt = '0;
          end
        end
      end
      ST_LOCKED: begin
        w_frame_err = w_vs_rise & ~w_match;
        if (w_frame_err || w_perr) begin
          w_state_nxt     = ST_MEASURE;
          w_match_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = ST_SEARCH;
        w_match_cnt_nxt = '0;
      end
    endcase
  end

  assign w_err_inc = {1'b0, w_frame_err} + {1'b0, w_perr};
  assign w_err_sum = {1'b0, err_count} + {15'd0, w_err_inc};

  // pixel_valid qualifies the pixel outputs for one cycle; there is no backpressure,
  // so a consumer must accept every cycle in which pixel_valid is high.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      locked      <= 1'b0;
      err_count   <= '0;
    end else begin
      pixel_valid <= w_pix;
      locked      <= (w_state_nxt == ST_LOCKED);
      err_count   <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      if (w_pix) begin
        pixel_color <= w_color;
        x_out       <= r_x;
        y_out       <= r_y;
        sof         <= (r_x == 16'd0) && (r_y == 16'd0);
        eol         <= ~r_de;
      end else begin
        pixel_color <= '0;
        x_out       <= '0;
        y_out       <= '0;
        sof         <= 1'b0;
        eol         <= 1'b0;
      end
    end
  end

`ifdef VIDEO_IN_CRC_EN
  function automatic logic [31:0] crc32_upd(input logic [31:0] crc, input logic [23:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  logic [31:0] r_crc, w_crc_acc;
  assign w_crc_acc = w_pix ? crc32_upd(r_crc, w_color) : r_crc;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc           <= 32'hFFFFFFFF;
      frame_crc       <= '0;
      frame_crc_valid <= 1'b0;
    end else begin
      frame_crc_valid <= 1'b0;
      if (w_vs_rise && w_active) begin
        frame_crc       <= w_crc_acc;
        frame_crc_valid <= 1'b1;
        r_crc           <= 32'hFFFFFFFF;
      end else begin
        r_crc <= w_crc_acc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_in_decoder.sv
// Bench for video_in_decoder in a small 8x4 mode: colour table, pixel scoreboard,
// lock/relock, frame mismatch, protocol error and asynchronous mid-line reset.
module tb_video_in_decoder;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [23:0] video_in_pData;
  logic        video_in_pHSync, video_in_pVSync, video_in_pVDE;
  logic [23:0] pixel_color;
  logic        pixel_valid, sof, eol, locked;
  logic [15:0] x_out, y_out, err_count;
  logic [1:0]  dbg_state;
`ifdef VIDEO_IN_CRC_EN
  logic [31:0] frame_crc;
  logic        frame_crc_valid;
`endif

  // clock / reset block
  always #5 pixel_clk = ~pixel_clk;

  video_in_decoder #(
    .H_ACTIVE_VIDEO(HA), .H_FRONT_PORCH(HF), .H_SYNC_WIDTH(HS), .H_BACK_PORCH(HB),
    .V_ACTIVE_VIDEO(VA), .V_FRONT_PORCH(VF), .V_SYNC_WIDTH(VS), .V_BACK_PORCH(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n),
    .video_in_pData(video_in_pData), .video_in_pHSync(video_in_pHSync),
    .video_in_pVSync(video_in_pVSync), .video_in_pVDE(video_in_pVDE),
    .pixel_color(pixel_color), .pixel_valid(pixel_valid),
    .x_out(x_out), .y_out(y_out), .sof(sof), .eol(eol),
    .locked(locked), .err_count(err_count), .dbg_state(dbg_state)
`ifdef VIDEO_IN_CRC_EN
    , .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
`endif
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [23:0] color;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  typedef struct {
    logic [23:0] din;
    logic [23:0] exp_color;
  } vec_t;

  logic [EXP_W-1:0] exp_q[$];
  vec_t vec[8];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  bit   tb_active = 1'b0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_color"}, 32'(pixel_color), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_y"}, 32'(y_out), 32'd0);
    check({tag, "_sof"}, 32'(sof), 32'd0);
    check({tag, "_eol"}, 32'(eol), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // scoreboard: pop on every pixel_valid, sampled on the falling edge
  always @(negedge pixel_clk) begin
    exp_t e;
    if (rst_n && pixel_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pixel: got pixel_valid=1 x=%0d y=%0d, expected no pixel", x_out, y_out);
      end else begin
        e = exp_q.pop_front();
        check("latency_cycle", 32'(cyc), e.cyc);
        check("pixel_color", 32'(pixel_color), 32'(e.color));
        check("x_out", 32'(x_out), 32'(e.x));
        check("y_out", 32'(y_out), 32'(e.y));
        check("sof", 32'(sof), 32'(e.sof));
        check("eol", 32'(eol), 32'(e.eol));
      end
    end
  end

  task automatic reset_mid_line();
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete();
    tb_active = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #3 rst_n = 1'b1;
    @(posedge pixel_clk);
    #1 valid_cnt = 0;
  endtask

  // driver: one frame, lines 0..VT-1; VSync rises at the start of line VA+VF
  task automatic send_frame(input int mod_line, input int mod_len, input bit lock_before,
                            input bit lock_after, input int exp_err, input int exp_valid,
                            input int rst_at, input bit use_vec);
    int          len, idx;
    logic        de, hs, vs;
    logic [23:0] d, ec;
    exp_t        e;
    idx = 0;
    valid_cnt = 0;
    for (int l = 0; l < VT; l++) begin
      for (int c = 0; c < HT; c++) begin
        len = (l == mod_line) ? mod_len : HA;
        de  = (l < VA) && (c < len);
        hs  = (c >= HA + HF) && (c < HA + HF + HS);
        vs  = (l >= VA + VF) && (l < VA + VF + VS);
        if (idx == rst_at) reset_mid_line();
        if (use_vec && l == 0 && c < 8) begin
          d  = vec[c].din;
          ec = vec[c].exp_color;
        end else begin
          d  = 24'($urandom);
          ec = {d[23:16], d[7:0], d[15:8]};
        end
        if (l == VA + VF && c == 0) tb_active = 1'b1;
        video_in_pData  = d;
        video_in_pHSync = hs;
        video_in_pVSync = vs;
        video_in_pVDE   = de;
        @(posedge pixel_clk);
        #1;
        if (tb_active && de) begin
          e.cyc   = 32'(cyc + 2);
          e.color = ec;
          e.x     = 16'(c);
          e.y     = 16'(l);
          e.sof   = (c == 0) && (l == 0);
          e.eol   = (c == len - 1);
          exp_q.push_back(e);
        end
        if (l == VA + VF && c == 0) check("locked_at_vs_rise", 32'(locked), 32'(lock_before));
        if (l == VA + VF && c == 1) begin
          check("locked_after_vs_rise", 32'(locked), 32'(lock_after));
          check("err_after_vs_rise", 32'(err_count), 32'(exp_err));
        end
        idx++;
      end
    end
    if (exp_valid >= 0) check("valid_per_frame", 32'(valid_cnt), 32'(exp_valid));
  endtask

  initial begin
    vec[0] = '{24'h112233, 24'h113322};
    vec[1] = '{24'hFF0000, 24'hFF0000};
    vec[2] = '{24'h00FF00, 24'h0000FF};
    vec[3] = '{24'h0000FF, 24'h00FF00};
    vec[4] = '{24'hA1B2C3, 24'hA1C3B2};
    vec[5] = '{24'h123456, 24'h125634};
    vec[6] = '{24'h000000, 24'h000000};
    vec[7] = '{24'hFFFFFF, 24'hFFFFFF};

    rst_n           = 1'b0;
    video_in_pData  = '0;
    video_in_pHSync = 1'b0;
    video_in_pVSync = 1'b0;
    video_in_pVDE   = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // lines: mod_line, mod_len, lock_before, lock_after, err, valid, rst_at, use_vec
    send_frame(-1, 8,  1'b0, 1'b0, 0, 0,  -1, 1'b0); // SEARCH -> MEASURE
    send_frame(-1, 8,  1'b0, 1'b0, 0, 32, -1, 1'b1); // colour table, match 1
    send_frame(-1, 8,  1'b0, 1'b1, 0, 32, -1, 1'b0); // match 2 -> locked
    send_frame(-1, 8,  1'b1, 1'b1, 0, 32, -1, 1'b0);
    send_frame(3,  9,  1'b1, 1'b0, 1, 33, -1, 1'b0); // 9-pixel last line -> mismatch
    send_frame(-1, 8,  1'b0, 1'b0, 1, 32, -1, 1'b0);
    send_frame(-1, 8,  1'b0, 1'b1, 1, 32, -1, 1'b0); // relock
    send_frame(0,  12, 1'b0, 1'b0, 2, 36, -1, 1'b0); // VDE across HSync -> drop
    send_frame(-1, 8,  1'b0, 1'b1, 2, 32, -1, 1'b0);
    send_frame(-1, 8,  1'b0, 1'b0, 0, -1, HT + 4, 1'b0); // reset mid-line
    send_frame(-1, 8,  1'b0, 1'b0, 0, 32, -1, 1'b0);

    repeat (4) @(posedge pixel_clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
